// File: rtl/fft_frame_ctrl_if.sv
// Signal bundle between the FFT frame controller and its surroundings:
// upstream sample stream, FFT core drive/status, result handshake and status.
interface fft_frame_ctrl_if #(
  parameter int W = 32
);
  logic [W-1:0] in_i;
  logic [W-1:0] in_q;
  logic         in_valid;
  logic         in_ready;

  logic [W-1:0] fft_i;
  logic [W-1:0] fft_q;
  logic         fft_start;
  logic         fft_busy;
  logic         fft_valid;
  logic [W-1:0] fft_real;
  logic [W-1:0] fft_imag;

  logic [W-1:0] res_real;
  logic [W-1:0] res_imag;
  logic         res_valid;
  logic         res_ready;

  logic         timeout_err;
  logic [15:0]  frame_cnt;

  // Controller side
  modport slave (
    input  in_i, in_q, in_valid,
    output in_ready,
    output fft_i, fft_q, fft_start,
    input  fft_busy, fft_valid, fft_real, fft_imag,
    output res_real, res_imag, res_valid,
    input  res_ready,
    output timeout_err, frame_cnt
  );

  // Environment side
  modport master (
    output in_i, in_q, in_valid,
    input  in_ready,
    input  fft_i, fft_q, fft_start,
    output fft_busy, fft_valid, fft_real, fft_imag,
    input  res_real, res_imag, res_valid,
    output res_ready,
    input  timeout_err, frame_cnt
  );
endinterface

// File: rtl/fft_frame_ctrl.sv
// Frame controller: buffers N complex samples, bursts them into the FFT delay
// line, starts the core, waits (bounded) for its result and hands it downstream.
module fft_frame_ctrl #(
  parameter int N       = 32,
  parameter int W       = 32,
  parameter int TIMEOUT = 1024
) (
  input logic         clk,
  input logic         reset,
  fft_frame_ctrl_if.slave bus
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [TW-1:0] LAST_CNT = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {FILL, BURST, START, WAIT, DONE} state_t;

  state_t        state, state_nxt;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] burst_idx;
  logic [IW-1:0] rd_idx;
  logic [TW-1:0] wait_cnt;
  logic [W-1:0]  buf_i [N];
  logic [W-1:0]  buf_q [N];

  logic          accept, fill_done, burst_done;
  logic          wait_hit, wait_expire, res_take;

  logic [W-1:0]  fft_i_q, fft_q_q, res_real_q, res_imag_q;
  logic          fft_start_q, in_ready_q, res_valid_q, timeout_err_q;
  logic [15:0]   frame_cnt_q;

  always_comb begin
    accept      = (state == FILL) && bus.in_valid;
    fill_done   = accept && (wr_idx == LAST_IDX);
    burst_done  = (state == BURST) && (burst_idx == LAST_IDX);
    wait_hit    = (state == WAIT) && bus.fft_valid;
    wait_expire = (state == WAIT) && !bus.fft_valid && (wait_cnt == LAST_CNT);
    res_take    = (state == DONE) && bus.res_ready;
    // Read address leads the burst index by one so the output register
    // holds buffer[k] exactly while burst_idx == k.
    rd_idx      = (state == BURST) ? burst_idx + IW'(1) : '0;

    state_nxt = state;
    case (state)
      FILL:    if (fill_done) state_nxt = BURST;
      BURST:   if (burst_done) state_nxt = START;
      START:   if (!bus.fft_busy) state_nxt = WAIT;
      WAIT: begin
        if (wait_hit)         state_nxt = DONE;
        else if (wait_expire) state_nxt = FILL;
      end
      DONE:    if (res_take) state_nxt = FILL;
      default: state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= FILL;
      wr_idx        <= '0;
      burst_idx     <= '0;
      wait_cnt      <= '0;
      fft_i_q       <= '0;
      fft_q_q       <= '0;
      fft_start_q   <= 1'b0;
      res_real_q    <= '0;
      res_imag_q    <= '0;
      in_ready_q    <= 1'b1;
      res_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      state <= state_nxt;

      if (accept) wr_idx <= fill_done ? '0 : wr_idx + IW'(1);

      if (state == BURST) burst_idx <= burst_done ? '0 : burst_idx + IW'(1);
      else                burst_idx <= '0;

      if (state == WAIT) wait_cnt <= wait_cnt + TW'(1);
      else               wait_cnt <= '0;

      if (state_nxt == BURST) begin
        fft_i_q <= buf_i[rd_idx];
        fft_q_q <= buf_q[rd_idx];
      end else begin
        fft_i_q <= '0;
        fft_q_q <= '0;
      end

      fft_start_q <= (state == START) && !bus.fft_busy;
      in_ready_q  <= (state_nxt == FILL);
      res_valid_q <= (state_nxt == DONE);

      if (wait_hit) begin
        res_real_q <= bus.fft_real;
        res_imag_q <= bus.fft_imag;
      end

      if (wait_expire) timeout_err_q <= 1'b1;
      if (res_take)    frame_cnt_q   <= frame_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      buf_i[wr_idx] <= bus.in_i;
      buf_q[wr_idx] <= bus.in_q;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.fft_i       = fft_i_q;
  assign bus.fft_q       = fft_q_q;
  assign bus.fft_start   = fft_start_q;
  assign bus.res_real    = res_real_q;
  assign bus.res_imag    = res_imag_q;
  assign bus.res_valid   = res_valid_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.frame_cnt   = frame_cnt_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: the stimulus process predicts burst
// contents, start times and results; a negedge monitor compares them.
module tb_fft_frame_ctrl;
  localparam int N       = 32;
  localparam int W       = 32;
  localparam int TIMEOUT = 1024;

  typedef struct packed {
    logic [W-1:0] re;
    logic [W-1:0] im;
    logic [15:0]  cnt;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  fft_frame_ctrl_if #(.W(W)) bus ();

  fft_frame_ctrl #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [W-1:0] exp_si [$];
  logic [W-1:0] exp_sq [$];
  int           burst_t [$];
  int           exp_start [$];
  res_t         exp_res [$];
  logic [15:0]  model_cnt = '0;
  logic         model_err = 1'b0;
  logic         cnt_pend = 1'b0;
  logic [15:0]  pend_cnt = '0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cycle %0d)", nm, got, want, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic junk();
    bus.in_valid = 1'($urandom);
    bus.in_i     = $urandom;
    bus.in_q     = $urandom;
    bus.fft_real = $urandom;
    bus.fft_imag = $urandom;
  endtask

  // One frame. gap: 0 continuous, 1 alternate, 2 random. vdelay <= 0 means no
  // fft_valid (timeout). rst_at >= 0 resets at that burst sample instead.
  task automatic run_frame(input int gap, input int busy_n, input int vdelay,
                           input int bp, input bit pattern, input int rst_at);
    int k, n, t, s, d, e;
    logic v;
    logic [W-1:0] re, im;
    k = 0;
    n = 0;
    while (k < N) begin
      if (gap == 0)      v = 1'b1;
      else if (gap == 1) v = (n % 2 == 0);
      else               v = 1'($urandom);
      junk();
      bus.in_valid  = v;
      if (pattern) begin
        bus.in_i = W'(k);
        bus.in_q = W'(100 + k);
      end
      bus.fft_valid = 1'($urandom);
      bus.fft_busy  = 1'($urandom);
      bus.res_ready = 1'($urandom);
      chk("in_ready_fill", {63'd0, bus.in_ready}, 64'd1);
      if (v) begin
        exp_si.push_back(bus.in_i);
        exp_sq.push_back(bus.in_q);
      end
      step();
      n++;
      if (v) k++;
    end
    t = cyc;
    burst_t.push_back(t);
    s = t + N + 1 + busy_n;
    exp_start.push_back(s);

    if (rst_at >= 0) begin
      while (cyc < t + rst_at) begin
        junk();
        bus.fft_valid = 1'($urandom);
        step();
      end
      exp_si.delete();
      exp_sq.delete();
      burst_t.delete();
      exp_start.delete();
      exp_res.delete();
      cnt_pend  = 1'b0;
      model_cnt = '0;
      model_err = 1'b0;
      reset = 1'b1;
      #1;
      chk("rst_fft_iq", {bus.fft_i, bus.fft_q}, '0);
      chk("rst_fft_start", {63'd0, bus.fft_start}, 64'd0);
      chk("rst_res_valid", {63'd0, bus.res_valid}, 64'd0);
      bus.in_valid = 1'b0;
      step();
      step();
      reset = 1'b0;
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("rst_frame_cnt", {48'd0, bus.frame_cnt}, 64'd0);
      return;
    end

    while (cyc < s) begin
      e = cyc + 1;
      junk();
      bus.fft_valid = 1'($urandom);
      bus.fft_busy  = (e < t + N + 1) ? 1'($urandom) : (e <= t + N + busy_n);
      step();
    end
    bus.fft_busy  = 1'b0;
    bus.fft_valid = 1'b0;

    if (vdelay > 0) begin
      while (cyc < s + vdelay) begin
        e = cyc + 1;
        junk();
        bus.fft_valid = (e == s + vdelay);
        if (bus.fft_valid) begin
          re = pattern ? 32'hA5A5_A5A5 : $urandom;
          im = pattern ? 32'h5A5A_5A5A : $urandom;
          bus.fft_real = re;
          bus.fft_imag = im;
          exp_res.push_back('{re: re, im: im, cnt: model_cnt + 16'd1});
          model_cnt = model_cnt + 16'd1;
        end
        step();
      end
      d = s + vdelay;
      while (cyc < d + bp + 1) begin
        e = cyc + 1;
        junk();
        bus.fft_valid = 1'($urandom);
        bus.res_ready = (e == d + bp + 1);
        step();
      end
      bus.res_ready = 1'b0;
    end else begin
      while (cyc < s + TIMEOUT) begin
        junk();
        bus.fft_valid = 1'b0;
        step();
      end
      model_err = 1'b1;
      chk("to_err_set", {63'd0, bus.timeout_err}, 64'd1);
      chk("to_in_ready", {63'd0, bus.in_ready}, 64'd1);
      chk("to_frame_cnt", {48'd0, bus.frame_cnt}, {48'd0, model_cnt});
    end
    bus.in_valid  = 1'b0;
    bus.fft_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (burst_t.size() > 0 && cyc >= burst_t[0] && cyc < burst_t[0] + N) begin
      chk("burst_sample", {bus.fft_i, bus.fft_q}, {exp_si.pop_front(), exp_sq.pop_front()});
      if (cyc == burst_t[0] + N - 1) burst_t.delete(0);
    end else begin
      chk("idle_zero", {bus.fft_i, bus.fft_q}, '0);
    end

    if (bus.fft_start) begin
      if (exp_start.size() == 0) chk("start_unexpected", {63'd0, bus.fft_start}, 64'd0);
      else                       chk("start_cycle", 64'(cyc), 64'(exp_start.pop_front()));
    end else if (exp_start.size() > 0 && cyc > exp_start[0]) begin
      chk("start_missing", {63'd0, bus.fft_start}, 64'd1);
      exp_start.delete(0);
    end

    if (cnt_pend) begin
      chk("frame_cnt_inc", {48'd0, bus.frame_cnt}, {48'd0, pend_cnt});
      chk("res_valid_drop", {63'd0, bus.res_valid}, 64'd0);
      cnt_pend = 1'b0;
    end
    if (bus.res_valid) begin
      chk("in_ready_done", {63'd0, bus.in_ready}, 64'd0);
      if (exp_res.size() == 0) begin
        chk("res_unexpected", {63'd0, bus.res_valid}, 64'd0);
      end else begin
        chk("res_data", {bus.res_real, bus.res_imag}, {exp_res[0].re, exp_res[0].im});
        chk("frame_cnt_hold", {48'd0, bus.frame_cnt}, {48'd0, exp_res[0].cnt - 16'd1});
        if (bus.res_ready) begin
          pend_cnt = exp_res[0].cnt;
          cnt_pend = 1'b1;
          exp_res.delete(0);
        end
      end
    end

    chk("timeout_err", {63'd0, bus.timeout_err}, {63'd0, model_err});
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.in_i      = '0;
    bus.in_q      = '0;
    bus.in_valid  = 1'b0;
    bus.fft_busy  = 1'b0;
    bus.fft_valid = 1'b0;
    bus.fft_real  = '0;
    bus.fft_imag  = '0;
    bus.res_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fft_iq", {bus.fft_i, bus.fft_q}, '0);
    chk("reset_res", {bus.res_real, bus.res_imag}, '0);
    chk("reset_flags", {60'd0, bus.fft_start, bus.res_valid, bus.timeout_err, bus.in_ready}, 64'd1);
    chk("reset_frame_cnt", {48'd0, bus.frame_cnt}, 64'd0);
    reset = 1'b0;

    run_frame(0, 0, 5, 0, 1'b1, -1);   // basic frame
    run_frame(1, 0, 7, 0, 1'b0, -1);   // gapped input
    run_frame(0, 10, 3, 0, 1'b0, -1);  // busy core
    run_frame(0, 0, 4, 7, 1'b0, -1);   // backpressure
    run_frame(0, 0, 0, 0, 1'b0, -1);   // timeout
    for (int r = 0; r < 4; r++)
      run_frame(2, int'($urandom_range(0, 4)), int'($urandom_range(1, 12)),
                int'($urandom_range(0, 3)), 1'b0, -1);
    run_frame(0, 0, 0, 0, 1'b1, 12);   // reset at burst sample 12
    run_frame(0, 0, 5, 0, 1'b1, -1);   // clean frame after reset

    repeat (4) step();
    chk("leftover_res", 64'(exp_res.size()), 64'd0);
    chk("leftover_start", 64'(exp_start.size()), 64'd0);
    chk("leftover_burst", 64'(burst_t.size()), 64'd0);
    chk("final_frame_cnt", {48'd0, bus.frame_cnt}, 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
